// File: rtl/alu_core.sv
// 32-bit execute-stage ALU: eight operations selected by op, result and zero
// flag registered together so the EX/MEM boundary sees a one-cycle latency.
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  op,
  input  logic [4:0]  sa,
  output logic [31:0] res,
  output logic        o_zf
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SRA = 3'b110,
    OP_SLT = 3'b111
  } alu_op_t;

  logic [31:0] result_nxt;

  always_comb begin
    result_nxt = 32'h0000_0000;
    case (alu_op_t'(op))
      OP_ADD: result_nxt = A + B;
      OP_SUB: result_nxt = A - B;
      OP_AND: result_nxt = A & B;
      OP_OR:  result_nxt = A | B;
      OP_SLL: result_nxt = B << sa;
      OP_SRL: result_nxt = B >> sa;
      OP_SRA: result_nxt = $unsigned($signed(B) >>> sa);
      OP_SLT: result_nxt = {31'd0, $signed(A) < $signed(B)};
      default: result_nxt = 32'h0000_0000;
    endcase
  end

  // Zero flag comes from the same value loaded into res, never a partial term.
  always_ff @(posedge clk) begin
    if (rst) begin
      res  <= 32'h0000_0000;
      o_zf <= 1'b1;
    end else begin
      res  <= result_nxt;
      o_zf <= (result_nxt == 32'h0000_0000);
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed vector table plus back-to-back stream with a mid-stream reset
// for alu_core.
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic [4:0]  sa;
  logic [31:0] res;
  logic        o_zf;

  int errors = 0;
  int checks = 0;

  alu_core dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .op   (op),
    .sa   (sa),
    .res  (res),
    .o_zf (o_zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  sa;
    logic [31:0] res;
    logic        zf;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] o, input logic [4:0] s);
    logic [63:0] wide;
    logic [31:0] r;
    r = 32'd0;
    case (o)
      3'd0: r = a + b;
      3'd1: r = a + (~b) + 32'd1;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = b << s;
      3'd5: r = b >> s;
      3'd6: begin
        wide = {{32{b[31]}}, b} >> s;
        r = wide[31:0];
      end
      default: begin
        if (a[31] != b[31]) r = {31'd0, a[31]};
        else                r = {31'd0, a < b};
      end
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] exp_res, input logic exp_zf);
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL %s res: got %h expected %h", name, res, exp_res);
    end
    checks++;
    if (o_zf !== exp_zf) begin
      errors++;
      $display("FAIL %s o_zf: got %b expected %b", name, o_zf, exp_zf);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] o, input logic [4:0] s);
    @(negedge clk);
    rst = r;
    A   = a;
    B   = b;
    op  = o;
    sa  = s;
  endtask

  initial begin
    logic [31:0] exp_r;
    logic [31:0] ra, rb;
    logic [4:0]  rs;
    logic [2:0]  ro;

    vecs[0]  = '{32'hDEAD_BEEF, 32'h8000_0000, 3'b101, 5'd31, 32'h0000_0001, 1'b0};
    vecs[1]  = '{32'h0000_0000, 32'h8000_0000, 3'b110, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'h1234_5678, 32'h0000_0001, 3'b100, 5'd31, 32'h8000_0000, 1'b0};
    vecs[3]  = '{32'h0000_0000, 32'h8000_0000, 3'b101, 5'd0,  32'h8000_0000, 1'b0};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 5'd31, 32'h0000_0000, 1'b1};
    vecs[5]  = '{32'h0000_0005, 32'h0000_0007, 3'b001, 5'd0,  32'hFFFF_FFFE, 1'b0};
    vecs[6]  = '{32'h1234_5678, 32'h1234_5678, 3'b001, 5'd7,  32'h0000_0000, 1'b1};
    vecs[7]  = '{32'hF0F0_0F0F, 32'h0FF0_F00F, 3'b010, 5'd0,  32'h00F0_000F, 1'b0};
    vecs[8]  = '{32'hF0F0_0F0F, 32'h0FF0_F00F, 3'b011, 5'd0,  32'hFFF0_FF0F, 1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 5'd0,  32'h0000_0001, 1'b0};
    vecs[10] = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b111, 5'd0,  32'h0000_0000, 1'b1};
    vecs[11] = '{32'h0000_0007, 32'h0000_0007, 3'b111, 5'd0,  32'h0000_0000, 1'b1};
    vecs[12] = '{32'h0000_0000, 32'h4000_0000, 3'b110, 5'd4,  32'h0400_0000, 1'b0};
    vecs[13] = '{32'hFFFF_FFFF, 32'hA5A5_0001, 3'b100, 5'd0,  32'hA5A5_0001, 1'b0};
    vecs[14] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 5'd0,  32'h0000_0001, 1'b0};
    vecs[15] = '{32'h0000_0000, 32'h0000_0001, 3'b101, 5'd1,  32'h0000_0000, 1'b1};

    rst = 1'b1;
    A   = 32'hFFFF_FFFF;
    B   = 32'hFFFF_FFFF;
    op  = 3'b000;
    sa  = 5'd0;

    // Reset held two edges with inputs that would otherwise give a nonzero sum.
    @(posedge clk); #1;
    check("reset_edge1", 32'h0000_0000, 1'b1);
    @(posedge clk); #1;
    check("reset_edge2", 32'h0000_0000, 1'b1);

    for (int i = 0; i < NV; i++) begin
      drive(1'b0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sa);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].res, vecs[i].zf);
    end

    // Outputs must hold between edges even when inputs change.
    drive(1'b0, 32'h0000_0003, 32'h0000_0004, 3'b000, 5'd0);
    @(posedge clk); #1;
    check("hold_pre", 32'h0000_0007, 1'b0);
    @(negedge clk);
    A = 32'h0; B = 32'h0;
    #2;
    check("hold_between_edges", 32'h0000_0007, 1'b0);

    // Back-to-back stream over all ops with a single-cycle reset in the middle.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 5'($urandom_range(0, 31));
      ro = 3'(i % 8);
      if (i == 20) begin
        drive(1'b1, ra, rb, ro, rs);
        @(posedge clk); #1;
        check("stream_mid_reset", 32'h0000_0000, 1'b1);
      end else begin
        drive(1'b0, ra, rb, ro, rs);
        exp_r = ref_alu(ra, rb, ro, rs);
        @(posedge clk); #1;
        check($sformatf("stream%0d_op%0d", i, ro), exp_r, exp_r == 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
